// File: rtl/lcd_host.sv
// ---------------------------------------------------------------------------
// lcd_host
//   Host/memory side of the LCD controller link. It serves image ROM reads to
//   the controller, feeds it queued commands under a busy handshake, captures
//   the controller's image RAM writes (with a running checksum and write
//   count) and flags completion or the first error of a session.
//
// Ports
//   clk, reset                    clock, synchronous active-low reset
//   ld_en/ld_sel/ld_addr/ld_data  loader: image bytes (sel=0) or opcodes (sel=1)
//   start                         session start pulse
//   IROM_rd/IROM_A/IROM_Q         controller image ROM read port
//   cmd/cmd_valid/busy            command strobe and controller busy
//   IRAM_valid/IRAM_A/IRAM_D      controller result RAM write port
//   done                          controller completion flag
//   rd_addr/rd_data               result memory read-back
//   checksum/wr_cnt/fin/err       session status
// ---------------------------------------------------------------------------
module lcd_host #(
    parameter int TIMEOUT = 255,
    parameter int QDEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_en,
    input  logic        ld_sel,
    input  logic [5:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        start,
    input  logic        IROM_rd,
    input  logic [5:0]  IROM_A,
    output logic [7:0]  IROM_Q,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    input  logic        busy,
    input  logic        IRAM_valid,
    input  logic [5:0]  IRAM_A,
    input  logic [7:0]  IRAM_D,
    input  logic        done,
    input  logic [5:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [13:0] checksum,
    output logic [6:0]  wr_cnt,
    output logic        fin,
    output logic [1:0]  err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAITRDY, S_ISSUE, S_HOLD, S_WAITBUSY, S_WAITDONE, S_FIN, S_ERR
    } state_e;

    localparam int             QAW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [QAW:0]   Q_FULL   = (QAW+1)'(QDEPTH);
    // The timer counts completed waiting cycles, so the last permitted one
    // is TIMEOUT-1; the edge that would make it TIMEOUT moves to ERR instead.
    localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [7:0]      timer_q, timer_d;
    logic [1:0]      err_q, err_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [6:0]      wr_cnt_q, wr_cnt_d;
    logic [13:0]     checksum_q, checksum_d;
    logic [QAW-1:0]  q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [QAW:0]    q_cnt_q, q_cnt_d;

    logic [7:0] img   [64];
    logic [7:0] res   [64];
    logic [3:0] q_mem [QDEPTH];

    logic load_ok, img_we, push_req, push_ok, q_full, q_empty;
    logic start_ok, capture, take_cmd;

    // Request decode shared by the FSM and the datapath.
    always_comb begin
        load_ok  = (state_q == S_IDLE) && ld_en;
        img_we   = load_ok && !ld_sel;
        push_req = load_ok && ld_sel;
        q_full   = (q_cnt_q == Q_FULL);
        q_empty  = (q_cnt_q == '0);
        push_ok  = push_req && !q_full;
        start_ok = start && ((state_q == S_IDLE) || (state_q == S_FIN) || (state_q == S_ERR));
        capture  = (state_q != S_IDLE) && IRAM_valid;
        // Leaving WAITRDY is the moment the next command is latched (and popped).
        take_cmd = (state_q == S_WAITRDY) && !busy;
    end

    // Next-state logic, including the wait timer and error code updates.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        err_d   = err_q;
        if (start_ok)            err_d = 2'd0;
        if (push_req && q_full)  err_d = 2'd2;
        case (state_q)
            S_IDLE:     if (start_ok) state_d = S_WAITRDY;
            S_WAITRDY:  if (!busy)    state_d = S_ISSUE;
            S_ISSUE:    state_d = S_HOLD;
            // Write-out (0) and 12..15 finish the session; the rest use busy.
            S_HOLD:     state_d = ((cmd_q == 4'd0) || (cmd_q >= 4'd12)) ? S_WAITDONE : S_WAITBUSY;
            S_WAITBUSY: begin
                if (!busy) begin
                    state_d = S_WAITRDY;
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 2'd1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_WAITDONE: begin
                if (done) begin
                    if (wr_cnt_q == 7'd64) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 2'd3;
                    end
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 2'd1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_FIN, S_ERR: if (start_ok) state_d = S_WAITRDY;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath: command register, queue pointers, capture counters.
    always_comb begin
        cmd_d      = cmd_q;
        q_rd_d     = q_rd_q;
        q_wr_d     = q_wr_q;
        q_cnt_d    = q_cnt_q;
        wr_cnt_d   = start_ok ? 7'd0  : wr_cnt_q;
        checksum_d = start_ok ? 14'd0 : checksum_q;
        if (take_cmd) begin
            if (q_empty) begin
                cmd_d = 4'd0;
            end else begin
                cmd_d   = q_mem[q_rd_q];
                q_rd_d  = q_rd_q + QAW'(1);
                q_cnt_d = q_cnt_q - (QAW+1)'(1);
            end
        end
        // Pushes only happen in IDLE and pops only in WAITRDY, so they never
        // collide on the count.
        if (push_ok) begin
            q_wr_d  = q_wr_q + QAW'(1);
            q_cnt_d = q_cnt_q + (QAW+1)'(1);
        end
        if (capture) begin
            checksum_d = checksum_d + 14'(IRAM_D);
            if (wr_cnt_d != 7'd64) wr_cnt_d = wr_cnt_d + 7'd1;
        end
    end

    // State and status registers.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            err_q      <= '0;
            cmd_q      <= '0;
            wr_cnt_q   <= '0;
            checksum_q <= '0;
            q_rd_q     <= '0;
            q_wr_q     <= '0;
            q_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            cmd_q      <= cmd_d;
            wr_cnt_q   <= wr_cnt_d;
            checksum_q <= checksum_d;
            q_rd_q     <= q_rd_d;
            q_wr_q     <= q_wr_d;
            q_cnt_q    <= q_cnt_d;
        end
    end

    // NOTE: the arrays have no reset; image and result contents must survive
    // a reset, and the queue is emptied through its pointers instead.
    always_ff @(posedge clk) begin
        if (img_we)  img[ld_addr]   <= ld_data;
        if (capture) res[IRAM_A]    <= IRAM_D;
        if (push_ok) q_mem[q_wr_q]  <= ld_data[3:0];
    end

    // Output decode.
    always_comb begin
        cmd_valid = (state_q == S_ISSUE);
        fin       = (state_q == S_FIN);
        cmd       = cmd_q;
        err       = err_q;
        wr_cnt    = wr_cnt_q;
        checksum  = checksum_q;
        IROM_Q    = IROM_rd ? img[IROM_A] : 8'h00;
        rd_data   = res[rd_addr];
    end

endmodule

// File: tb/tb_lcd_host.sv
// ---------------------------------------------------------------------------
// tb_lcd_host
//   Directed bench for lcd_host. A small controller model answers each
//   cmd_valid pulse with two busy-high cycles and, after the write-out
//   command, optionally writes 64 bytes of 0xFF before raising done.
// ---------------------------------------------------------------------------
module tb_lcd_host;

    logic        clk = 1'b0;
    logic        reset, ld_en, ld_sel, start, IROM_rd, busy, IRAM_valid, done;
    logic [5:0]  ld_addr, IROM_A, IRAM_A, rd_addr;
    logic [7:0]  ld_data, IRAM_D;
    logic [7:0]  IROM_Q, rd_data;
    logic [3:0]  cmd;
    logic        cmd_valid, fin;
    logic [13:0] checksum;
    logic [6:0]  wr_cnt;
    logic [1:0]  err;

    int total = 0;
    int bad   = 0;

    logic [3:0] seen_cmd[$];
    int         seen_cyc[$];
    bit         wide;
    bit         expired;

    always #5 clk = ~clk;

    lcd_host dut (
        .clk(clk), .reset(reset),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start),
        .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
        .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
        .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D),
        .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .checksum(checksum), .wr_cnt(wr_cnt), .fin(fin), .err(err)
    );

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; ld_en = 1'b0; start = 1'b0; busy = 1'b0;
        IRAM_valid = 1'b0; done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push_cmd(input logic [3:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 6'd0; ld_data = {4'h0, v};
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ld_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Controller model; runs until fin or a nonzero err, or the cycle budget.
    task automatic run_ctrl(input bit do_writes, input int max_cyc);
        int busy_left = 0;
        bit prev_v    = 1'b0;
        bit term_seen = 1'b0;
        int wr_k      = 0;
        seen_cmd.delete(); seen_cyc.delete();
        wide = 1'b0; expired = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            IRAM_valid = 1'b0; done = 1'b0;
            if (fin || err != 2'd0) begin
                expired = 1'b0;
                break;
            end
            if (cmd_valid) begin
                seen_cmd.push_back(cmd);
                seen_cyc.push_back(c);
                if (prev_v) wide = 1'b1;
                if (cmd == 4'd0) term_seen = 1'b1;
                busy = 1'b1; busy_left = 2;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) busy = 1'b0;
            end
            prev_v = cmd_valid;
            if (term_seen && !cmd_valid) begin
                if (do_writes && wr_k < 64) begin
                    IRAM_valid = 1'b1; IRAM_A = 6'(wr_k); IRAM_D = 8'hFF;
                    wr_k++;
                end else begin
                    done = 1'b1;
                end
            end
        end
        IRAM_valid = 1'b0; done = 1'b0; busy = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; IROM_rd = 1'b0; IROM_A = '0; busy = 1'b0;
        IRAM_valid = 1'b0; IRAM_A = '0; IRAM_D = '0; done = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({cmd_valid, cmd, fin, err, wr_cnt, checksum} !== 29'd0) begin
            bad++;
            $display("FAIL reset_outputs: got cv=%b cmd=%0d fin=%b err=%0d wr=%0d sum=%0d want all 0",
                     cmd_valid, cmd, fin, err, wr_cnt, checksum);
        end
        reset = 1'b1;
    endtask

    task automatic test_rom();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 6'(i); ld_data = 8'(i);
        end
        @(negedge clk);
        ld_en = 1'b0;
        IROM_rd = 1'b1; IROM_A = 6'h2A; #1;
        total++;
        if (IROM_Q !== 8'h2A) begin bad++; $display("FAIL rom_2a: got %h want 2a", IROM_Q); end
        IROM_A = 6'h3F; #1;
        total++;
        if (IROM_Q !== 8'h3F) begin bad++; $display("FAIL rom_3f: got %h want 3f", IROM_Q); end
        IROM_rd = 1'b0; IROM_A = 6'h2A; #1;
        total++;
        if (IROM_Q !== 8'h00) begin bad++; $display("FAIL rom_rd_low: got %h want 00", IROM_Q); end
    endtask

    task automatic test_queue_order();
        do_reset();
        push_cmd(4'd1);
        push_cmd(4'd5);
        pulse_start();
        run_ctrl(1'b0, 500);
        total++;
        if (expired) begin bad++; $display("FAIL order_budget: session did not end"); end
        total++;
        if (seen_cmd.size() != 3) begin
            bad++; $display("FAIL order_count: got %0d pulses want 3", seen_cmd.size());
        end else begin
            total++;
            if ({seen_cmd[0], seen_cmd[1], seen_cmd[2]} !== 12'h150) begin
                bad++;
                $display("FAIL order_values: got %0d,%0d,%0d want 1,5,0", seen_cmd[0], seen_cmd[1], seen_cmd[2]);
            end
            total++;
            if (seen_cyc[1] - seen_cyc[0] < 4 || seen_cyc[2] - seen_cyc[1] < 4) begin
                bad++;
                $display("FAIL order_gap: got gaps %0d,%0d want >=4", seen_cyc[1] - seen_cyc[0], seen_cyc[2] - seen_cyc[1]);
            end
        end
        total++;
        if (wide !== 1'b0) begin bad++; $display("FAIL order_width: got a multi-cycle pulse want single-cycle"); end
        // No writes happened before done, so the session ends in error 3.
        total++;
        if (err !== 2'd3 || fin !== 1'b0) begin
            bad++; $display("FAIL order_err3: got err=%0d fin=%b want err=3 fin=0", err, fin);
        end
    endtask

    task automatic test_capture_fin();
        // Restart straight from ERR; the image memory must stay as loaded.
        pulse_start();
        total++;
        if (err !== 2'd0 || wr_cnt !== 7'd0) begin
            bad++; $display("FAIL restart_clear: got err=%0d wr=%0d want 0,0", err, wr_cnt);
        end
        run_ctrl(1'b1, 500);
        total++;
        if (expired || fin !== 1'b1 || err !== 2'd0) begin
            bad++; $display("FAIL cap_fin: got fin=%b err=%0d expired=%b want fin=1 err=0", fin, err, expired);
        end
        total++;
        if (wr_cnt !== 7'd64) begin bad++; $display("FAIL cap_wr_cnt: got %0d want 64", wr_cnt); end
        total++;
        if (checksum !== 14'd16320) begin bad++; $display("FAIL cap_checksum: got %0d want 16320", checksum); end
        rd_addr = 6'd63; #1;
        total++;
        if (rd_data !== 8'hFF) begin bad++; $display("FAIL cap_rd63: got %h want ff", rd_data); end
        total++;
        if (seen_cmd.size() != 1) begin bad++; $display("FAIL cap_cmds: got %0d pulses want 1", seen_cmd.size()); end
        // In FIN: an image load is ignored, a capture saturates wr_cnt.
        ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 6'h2A; ld_data = 8'h99;
        IRAM_valid = 1'b1; IRAM_A = 6'd5; IRAM_D = 8'h01;
        @(negedge clk);
        ld_en = 1'b0; IRAM_valid = 1'b0;
        IROM_rd = 1'b1; IROM_A = 6'h2A; rd_addr = 6'd5; #1;
        total++;
        if (wr_cnt !== 7'd64 || checksum !== 14'd16321) begin
            bad++; $display("FAIL cap_saturate: got wr=%0d sum=%0d want 64,16321", wr_cnt, checksum);
        end
        total++;
        if (IROM_Q !== 8'h2A) begin bad++; $display("FAIL load_outside_idle: got %h want 2a", IROM_Q); end
        total++;
        if (rd_data !== 8'h01 || fin !== 1'b1) begin
            bad++; $display("FAIL fin_hold: got rd=%h fin=%b want 01,1", rd_data, fin);
        end
        IROM_rd = 1'b0;
    endtask

    task automatic test_timeout();
        bit got_pulse = 1'b0;
        int late_pulses = 0;
        do_reset();
        IROM_rd = 1'b1; IROM_A = 6'h2A; rd_addr = 6'd63; #1;
        total++;
        if (IROM_Q !== 8'h2A || rd_data !== 8'hFF) begin
            bad++; $display("FAIL reset_keeps_mem: got rom=%h res=%h want 2a,ff", IROM_Q, rd_data);
        end
        IROM_rd = 1'b0;
        push_cmd(4'd1);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid) begin got_pulse = 1'b1; break; end
        end
        total++;
        if (!got_pulse) begin bad++; $display("FAIL tmo_issue: got no cmd_valid within 20 cycles want one"); end
        busy = 1'b1;
        for (int n = 1; n <= 257; n++) begin
            @(negedge clk);
            if (n == 256) begin
                total++;
                if (err !== 2'd0) begin bad++; $display("FAIL tmo_early: got err=%0d at 254 busy cycles want 0", err); end
            end
            if (n == 257) begin
                total++;
                if (err !== 2'd1) begin bad++; $display("FAIL tmo_err: got err=%0d at 255 busy cycles want 1", err); end
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) busy = 1'b0;
            if (cmd_valid) late_pulses++;
        end
        total++;
        if (late_pulses != 0 || err !== 2'd1) begin
            bad++; $display("FAIL tmo_quiet: got %0d pulses err=%0d want 0 pulses err=1", late_pulses, err);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_cmd;
        do_reset();
        for (int i = 0; i < 17; i++) push_cmd((i < 16) ? 4'((i % 11) + 1) : 4'd7);
        @(negedge clk);
        ld_en = 1'b0;
        total++;
        if (err !== 2'd2) begin bad++; $display("FAIL ovf_err: got err=%0d want 2", err); end
        pulse_start();
        run_ctrl(1'b0, 2000);
        total++;
        if (seen_cmd.size() != 17) begin
            bad++; $display("FAIL ovf_count: got %0d pulses want 17", seen_cmd.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                exp_cmd = (i < 16) ? 4'((i % 11) + 1) : 4'd0;
                total++;
                if (seen_cmd[i] !== exp_cmd) begin
                    bad++; $display("FAIL ovf_cmd%0d: got %0d want %0d", i, seen_cmd[i], exp_cmd);
                end
            end
        end
        total++;
        if (expired || err !== 2'd3) begin
            bad++; $display("FAIL ovf_end: got err=%0d expired=%b want err=3", err, expired);
        end
    endtask

    task automatic test_reset_mid();
        bit got_pulse = 1'b0;
        int late_pulses = 0;
        do_reset();
        push_cmd(4'd1);
        busy = 1'b1;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            IRAM_valid = 1'b1; IRAM_A = 6'(10 + i); IRAM_D = 8'(3 + i);
        end
        @(negedge clk);
        IRAM_valid = 1'b0;
        total++;
        if (wr_cnt !== 7'd3 || checksum !== 14'd12) begin
            bad++; $display("FAIL mid_capture: got wr=%0d sum=%0d want 3,12", wr_cnt, checksum);
        end
        busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid) begin got_pulse = 1'b1; break; end
        end
        busy = 1'b1;
        @(negedge clk);
        total++;
        if (!got_pulse || cmd !== 4'd1 || cmd_valid !== 1'b0) begin
            bad++; $display("FAIL cmd_hold: got pulse=%b cmd=%0d cv=%b want 1,1,0", got_pulse, cmd, cmd_valid);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        total++;
        if ({cmd_valid, cmd, fin, err, wr_cnt, checksum} !== 29'd0) begin
            bad++;
            $display("FAIL mid_reset: got cv=%b cmd=%0d fin=%b err=%0d wr=%0d sum=%0d want all 0",
                     cmd_valid, cmd, fin, err, wr_cnt, checksum);
        end
        busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_valid) late_pulses++;
        end
        total++;
        if (late_pulses != 0) begin bad++; $display("FAIL mid_quiet: got %0d pulses want 0", late_pulses); end
    endtask

    initial begin
        test_reset();
        test_rom();
        test_queue_order();
        test_capture_fin();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
